// File: rtl/temp_spi_rd.sv
// Periodic read-only SPI master for a MAX6675-style thermocouple sensor.
// Clocks in one 16-bit frame per sample period and latches raw/temp/fault.
module temp_spi_rd #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic [15:0] raw,
    output logic [11:0] temp,
    output logic        fault,
    output logic        temp_vld
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [DW-1:0]  div_cnt;
    logic [4:0]     bit_cnt;
    logic [15:0]    shift_reg;
    logic           start;
    logic           div_done;

    assign start    = (timer == TIMER_LAST);
    assign div_done = (div_cnt == DIV_LAST);

    // Free-running sample timer, independent of the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (start) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            spi_sclk  <= 1'b0;
            spi_cs_n  <= 1'b1;
            raw       <= '0;
            temp      <= '0;
            fault     <= 1'b0;
            temp_vld  <= 1'b0;
        end else begin
            temp_vld <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        div_cnt   <= '0;
                        spi_sclk  <= 1'b1;
                        shift_reg <= {shift_reg[14:0], spi_miso};
                        bit_cnt   <= 5'd1;
                        state     <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        // Sample on the clk edge that drives sclk high.
                        if (!spi_sclk) begin
                            shift_reg <= {shift_reg[14:0], spi_miso};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else if (bit_cnt == 5'd16) begin
                            state <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        spi_cs_n <= 1'b1;
                        raw      <= shift_reg;
                        temp     <= shift_reg[14:3];
                        fault    <= shift_reg[2];
                        temp_vld <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_spi_rd.sv
// Directed bench for temp_spi_rd: instance 0 uses CLK_DIV=2/SAMPLE_PERIOD=100,
// instance 1 uses CLK_DIV=1/SAMPLE_PERIOD=40; each has a sensor model and a bus monitor.
module tb_temp_spi_rd;

    logic        clk;
    logic        rst;
    logic [15:0] word_a;
    logic [15:0] word_b;
    int          cyc;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int CD = (gi == 0) ? 2 : 1;
        localparam int SP = (gi == 0) ? 100 : 40;

        logic        spi_miso;
        logic        spi_sclk;
        logic        spi_cs_n;
        logic [15:0] raw;
        logic [11:0] temp;
        logic        fault;
        logic        temp_vld;
        logic [15:0] word;
        int          vld_cnt;

        assign word = (gi == 0) ? word_a : word_b;

        temp_spi_rd #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
            .clk      (clk),
            .rst      (rst),
            .spi_miso (spi_miso),
            .spi_sclk (spi_sclk),
            .spi_cs_n (spi_cs_n),
            .raw      (raw),
            .temp     (temp),
            .fault    (fault),
            .temp_vld (temp_vld)
        );

        // Sensor: MSB valid while cs_n falls, next bit after each sclk fall.
        initial begin
            int   idx;
            logic prev_s;
            idx      = 15;
            prev_s   = 1'b0;
            spi_miso = 1'b0;
            forever begin
                @(negedge clk);
                if (rst || spi_cs_n) idx = 15;
                else if (prev_s && !spi_sclk && idx > 0) idx--;
                spi_miso = word[idx];
                prev_s   = spi_sclk;
            end
        end

        // Bus monitor: idle sclk, phase widths, frame length and edge count.
        initial begin
            logic prev_cs;
            logic prev_sclk;
            int   low_cnt;
            int   rises;
            int   phase;
            prev_cs = 1'b1; prev_sclk = 1'b0; low_cnt = 0; rises = 0; phase = 0;
            vld_cnt = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_cs = 1'b1; prev_sclk = 1'b0; low_cnt = 0; rises = 0; phase = 0;
                end else begin
                    if (temp_vld) vld_cnt++;
                    if (spi_cs_n) check($sformatf("sclk_idle%0d", gi), {31'd0, spi_sclk}, 32'd0);
                    if (!spi_cs_n) low_cnt++;
                    if (prev_cs && !spi_cs_n) begin
                        phase = 1;
                    end else if (!spi_cs_n || !prev_cs) begin
                        if (spi_sclk != prev_sclk || (spi_cs_n && !prev_cs)) begin
                            check($sformatf("phase_len%0d", gi), phase, CD);
                            phase = 1;
                        end else begin
                            phase++;
                        end
                    end
                    if (spi_sclk && !prev_sclk && !spi_cs_n) rises++;
                    if (spi_cs_n && !prev_cs) begin
                        check($sformatf("cs_low%0d", gi), low_cnt, 33 * CD);
                        check($sformatf("rises%0d", gi), rises, 16);
                        low_cnt = 0;
                        rises   = 0;
                    end
                    prev_cs   = spi_cs_n;
                    prev_sclk = spi_sclk;
                end
            end
        end
    end

    task automatic wait_vld(input int limit, output int at);
        bit found;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (g_inst[0].temp_vld) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        if (!found) check("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int at, input int exp_at,
                               input logic [15:0] exp_raw);
        $display("frame %s: cycle=%0d raw=%h temp=%h fault=%b", tag, at,
                 g_inst[0].raw, g_inst[0].temp, g_inst[0].fault);
        check({tag, "_cycle"}, at, exp_at);
        check({tag, "_raw"}, {16'd0, g_inst[0].raw}, {16'd0, exp_raw});
        check({tag, "_temp"}, {20'd0, g_inst[0].temp}, {20'd0, exp_raw[14:3]});
        check({tag, "_fault"}, {31'd0, g_inst[0].fault}, {31'd0, exp_raw[2]});
        @(negedge clk);
        check({tag, "_vld_1cyc"}, {31'd0, g_inst[0].temp_vld}, 32'd0);
    endtask

    initial begin
        int at;
        int last;
        int cnt0;
        logic [15:0] w;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        word_a = 16'h0C80;
        word_b = 16'hA5A5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", {31'd0, g_inst[0].spi_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, g_inst[0].spi_sclk}, 32'd0);
        check("rst_raw", {16'd0, g_inst[0].raw}, 32'd0);
        check("rst_temp", {20'd0, g_inst[0].temp}, 32'd0);
        check("rst_fault", {31'd0, g_inst[0].fault}, 32'd0);
        check("rst_vld", {31'd0, g_inst[0].temp_vld}, 32'd0);
        rst = 1'b0;

        // First frame: 0x0C80 -> temp 0x190 at cycle 166.
        wait_vld(300, at);
        check_frame("f0C80", at, 166, 16'h0C80);
        check("temp_0C80", {20'd0, g_inst[0].temp}, 32'h190);

        // Fault frame.
        word_a = 16'h0004;
        wait_vld(300, at);
        check_frame("f0004", at, 266, 16'h0004);
        check("fault_set", {31'd0, g_inst[0].fault}, 32'd1);
        last = at;

        // Free run, alternating full-scale and one LSB.
        for (int i = 0; i < 5; i++) begin
            w      = (i % 2 == 0) ? 16'h7FF8 : 16'h0008;
            word_a = w;
            cnt0   = g_inst[0].vld_cnt;
            wait_vld(300, at);
            check_frame($sformatf("run%0d", i), at, last + 100, w);
            check($sformatf("run%0d_temp", i), {20'd0, g_inst[0].temp},
                  (i % 2 == 0) ? 32'hFFF : 32'h001);
            check($sformatf("run%0d_pulses", i), g_inst[0].vld_cnt - cnt0, 1);
            last = at;
        end

        // Reset in the middle of the shift phase.
        at = 0;
        for (int i = 0; i < 200 && at == 0; i++) begin
            @(negedge clk);
            if (!g_inst[0].spi_cs_n) at = 1;
        end
        check("cs_fall_seen", at, 1);
        repeat (19) @(posedge clk);
        #1;
        check("pre_abort_sclk", {31'd0, g_inst[0].spi_sclk}, 32'd1);
        cnt0 = g_inst[0].vld_cnt;
        rst  = 1'b1;
        #1;
        check("abort_cs_n", {31'd0, g_inst[0].spi_cs_n}, 32'd1);
        check("abort_sclk", {31'd0, g_inst[0].spi_sclk}, 32'd0);
        check("abort_raw", {16'd0, g_inst[0].raw}, 32'd0);
        check("abort_vld", {31'd0, g_inst[0].temp_vld}, 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        word_a = 16'h0C80;
        repeat (150) @(negedge clk);
        check("abort_raw_hold", {16'd0, g_inst[0].raw}, 32'd0);
        check("abort_no_vld", g_inst[0].vld_cnt - cnt0, 0);
        wait_vld(300, at);
        check_frame("post_rst", at, 166, 16'h0C80);

        // CLK_DIV=1 instance has been free-running on 0xA5A5.
        check("div1_raw", {16'd0, g_inst[1].raw}, 32'hA5A5);
        check("div1_fault", {31'd0, g_inst[1].fault}, 32'd1);
        check("div1_seen", {31'd0, g_inst[1].vld_cnt > 0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
